// File: rtl/pixel_stream_sink.sv
// pixel_stream_sink
//   Receiving end of the pixel-plot stream. Plots are buffered in a small FIFO,
//   converted to a linear frame address (y*SCREEN_W + x) and written into an
//   external single-port synchronous frame RAM. The same RAM port also serves
//   scan-out read requests, and an arbiter FSM shares the port between them.
//
//   Optional feature: define PIXEL_SINK_CLIP_EN to discard plots that fall
//   outside the visible area. Each discarded plot is counted in drop_count.
//
// Ports
//   clock, reset_n           sole clock (rising edge), async active-low reset
//   x_in, y_in, colour_in    plot coordinate and colour
//   plot                     plot strobe, one pixel per cycle
//   full                     FIFO holds FIFO_DEPTH entries
//   rd_req, rd_addr          scan-out read request (held until rd_ack)
//   rd_ack                   read accepted at the coming edge
//   rd_valid, rd_data        read data return, two edges after rd_ack
//   mem_addr/wdata/we        registered RAM port
//   mem_rdata                RAM read data, one cycle after address sample
//   clr_status               clears drop_count and overflow
//   drop_count, overflow     saturating drop counter, sticky full-drop flag
//   idle                     FIFO empty and no RAM access in flight
//
// Port arbiter
//   state  | meaning
//   P_IDLE | no RAM access issued this cycle
//   P_RD   | scan-out read address on the RAM port
//   P_WR   | FIFO head being written to RAM

module pixel_stream_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  x_in,
  input  logic [6:0]  y_in,
  input  logic [2:0]  colour_in,
  input  logic        plot,
  output logic        full,
  input  logic        rd_req,
  input  logic [14:0] rd_addr,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [2:0]  rd_data,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_wdata,
  output logic        mem_we,
  input  logic [2:0]  mem_rdata,
  input  logic        clr_status,
  output logic [7:0]  drop_count,
  output logic        overflow,
  output logic        idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [14:0]   W15     = 15'(SCREEN_W);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pixel_stream_sink: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (SCREEN_W > 256 || SCREEN_H > 128) begin : g_bad_screen
    $error("pixel_stream_sink: screen does not fit the coordinate inputs");
  end

  typedef enum logic [1:0] {P_IDLE, P_RD, P_WR} port_state_t;
  port_state_t state, state_next;

  logic [17:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          pop, push;
  logic          in_range;
  logic          drop_clip, drop_full;
  logic [14:0]   plot_addr;
  logic [17:0]   head;
  logic          rd_pend;

  assign plot_addr = 15'(y_in) * W15 + 15'(x_in);

`ifdef PIXEL_SINK_CLIP_EN
  assign in_range = (x_in < 8'(SCREEN_W)) && (y_in < 7'(SCREEN_H));
`else
  assign in_range = 1'b1;
`endif

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];

  // A full FIFO forces a write so the drawing path cannot be starved by a
  // continuous scan-out request.
  always_comb begin
    state_next = P_IDLE;
    rd_ack     = 1'b0;
    pop        = 1'b0;
    if (full && !empty) begin
      state_next = P_WR;
      pop        = 1'b1;
    end else if (rd_req) begin
      state_next = P_RD;
      rd_ack     = 1'b1;
    end else if (!empty) begin
      state_next = P_WR;
      pop        = 1'b1;
    end
  end

  // A plot into a full FIFO still fits when the head leaves at the same edge.
  assign drop_clip = plot && !in_range;
  assign drop_full = plot && in_range && full && !pop;
  assign push      = plot && in_range && (!full || pop);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {plot_addr, colour_in};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= P_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rd_pend   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      case (state_next)
        P_WR: begin
          mem_addr  <= head[17:3];
          mem_wdata <= head[2:0];
          mem_we    <= 1'b1;
        end
        P_RD: begin
          mem_addr <= rd_addr;
          mem_we   <= 1'b0;
        end
        default: mem_we <= 1'b0;
      endcase

      // Read return pipeline: the RAM samples the address one edge after the
      // ack, and its data is captured one edge later.
      rd_pend  <= (state == P_RD);
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr_status) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if ((drop_clip || drop_full) && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (drop_full) overflow <= 1'b1;
    end
  end

  assign idle = empty && (state == P_IDLE) && !rd_pend;

endmodule

// File: tb/tb_pixel_stream_sink.sv
module tb_pixel_stream_sink;

`ifdef PIXEL_SINK_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic [7:0]  x_in       = '0;
  logic [6:0]  y_in       = '0;
  logic [2:0]  colour_in  = '0;
  logic        plot       = 1'b0;
  logic        full;
  logic        rd_req     = 1'b0;
  logic [14:0] rd_addr    = '0;
  logic        rd_ack;
  logic        rd_valid;
  logic [2:0]  rd_data;
  logic [14:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_rdata;
  logic        clr_status = 1'b0;
  logic [7:0]  drop_count;
  logic        overflow;
  logic        idle;

  int n_err = 0;
  int n_chk = 0;

  always #5 clock = ~clock;

  pixel_stream_sink dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .plot       (plot),
    .full       (full),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .clr_status (clr_status),
    .drop_count (drop_count),
    .overflow   (overflow),
    .idle       (idle)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame RAM model. Addresses above the largest plot address return a fixed
  // pattern so scan-out reads there have a known answer.
  logic [2:0] ram [0:32767];

  function automatic logic [2:0] pat(input logic [14:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6];
  endfunction

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr >= 15'd20576) ? pat(mem_addr) : ram[mem_addr];
  end

  // Reference model: plots expected in RAM in arrival order, reads expected
  // back exactly three observation cycles after the ack is seen.
  typedef struct { int due; logic [2:0] data; } rd_exp_t;
  logic [17:0] wrq [$];
  rd_exp_t     rdq [$];
  logic [2:0]  shadow [0:20575];
  int          exp_drop = 0;
  int          cyc = 0;
  int          n_we = 0;
  bit          ack_seen = 1'b0;

  function automatic logic [2:0] exp_rd(input logic [14:0] a);
    if (a >= 15'd20576) return pat(a);
    return shadow[a];
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin : monitor
    logic [17:0] e;
    rd_exp_t     r;
    ack_seen = rd_ack;
    if (reset_n) begin
      if (rd_ack) rdq.push_back('{due: cyc + 3, data: exp_rd(rd_addr)});
      if (mem_we) begin
        n_we++;
        if (wrq.size() == 0) check_val("wr_unexpected", 32'(mem_we), 0);
        else begin
          e = wrq.pop_front();
          check_val("wr_addr", 32'(mem_addr), 32'(e[17:3]));
          check_val("wr_data", 32'(mem_wdata), 32'(e[2:0]));
        end
      end
      if (rdq.size() != 0 && rdq[0].due == cyc) begin
        r = rdq.pop_front();
        check_val("rd_valid", 32'(rd_valid), 1);
        check_val("rd_data", 32'(rd_data), 32'(r.data));
      end else begin
        check_val("rd_valid_quiet", 32'(rd_valid), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c, input logic clr);
    logic [14:0] a;
    plot       = 1'b1;
    x_in       = x;
    y_in       = y;
    colour_in  = c;
    clr_status = clr;
    a = 15'(y) * 15'd160 + 15'(x);
    if (CLIP && (x >= 8'd160 || y >= 7'd120)) begin
      if (!clr && exp_drop < 255) exp_drop++;
    end else begin
      wrq.push_back({a, c});
      shadow[a] = c;
    end
    if (clr) exp_drop = 0;
  endtask

  task automatic no_plot(input logic clr);
    plot       = 1'b0;
    clr_status = clr;
    if (clr) exp_drop = 0;
  endtask

  task automatic drain(input string tag);
    no_plot(1'b0);
    rd_req = 1'b0;
    for (int i = 0; i < 60 && (wrq.size() != 0 || rdq.size() != 0); i++) tick();
    check_val(tag, 32'(wrq.size() + rdq.size()), 0);
    tick();
    tick();
    check_val({tag, "_idle"}, 32'(idle), 1);
  endtask

  initial begin : stim
    logic [7:0] ack_bits;
    logic [7:0] full_bits;
    int         we_snap;

    // Reset values
    #23;
    check_val("rst_mem_we", 32'(mem_we), 0);
    check_val("rst_full", 32'(full), 0);
    check_val("rst_idle", 32'(idle), 1);
    check_val("rst_rd_valid", 32'(rd_valid), 0);
    check_val("rst_mem_addr", 32'(mem_addr), 0);
    check_val("rst_drop", 32'(drop_count), 0);
    reset_n = 1'b1;
    tick();

    // Single plot: written one cycle after it is sampled, then idle
    drive_plot(8'd3, 7'd2, 3'b010, 1'b0);
    tick();
    no_plot(1'b0);
    tick();
    check_val("single_we", 32'(mem_we), 1);
    check_val("single_addr", 32'(mem_addr), 323);
    check_val("single_data", 32'(mem_wdata), 2);
    tick();
    check_val("single_idle", 32'(idle), 1);
    drain("single_drain");

    // Scan-out read of a pixel plotted at (159,119) = 19199, then a second read
    drive_plot(8'd159, 7'd119, 3'd5, 1'b0);
    tick();
    drain("rd_prep");
    rd_req  = 1'b1;
    rd_addr = 15'd19199;
    #1 check_val("rd0_ack", 32'(rd_ack), 1);
    tick();
    rd_addr = 15'd20600;
    #1 check_val("rd1_ack", 32'(rd_ack), 1);
    tick();
    rd_req = 1'b0;
    tick();
    check_val("rd0_valid_e2", 32'(rd_valid), 1);
    check_val("rd0_data_e2", 32'(rd_data), 5);
    tick();
    check_val("rd1_valid_e3", 32'(rd_valid), 1);
    check_val("rd1_data_e3", 32'(rd_data), 32'(pat(15'd20600)));
    tick();
    check_val("rd_done", 32'(rd_valid), 0);
    drain("rd_drain");

    // Burst of 6 plots with rd_req held high
    rd_req  = 1'b1;
    rd_addr = 15'd21000;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive_plot(8'(20 + i), 7'(10 + i), 3'(i + 1), 1'b0);
      else no_plot(1'b0);
      #1;
      ack_bits[i]  = rd_ack;
      full_bits[i] = full;
      tick();
    end
    check_val("burst_acks", 32'(ack_bits), 32'h8F);
    check_val("burst_full", 32'(full_bits), 32'h70);
    check_val("burst_drop", 32'(drop_count), 0);
    check_val("burst_ovf", 32'(overflow), 0);
    drain("burst_drain");

    // Off-screen plots
    drive_plot(8'd160, 7'd0, 3'd1, 1'b0);
    tick();
    drive_plot(8'd0, 7'd120, 3'd7, 1'b0);
    tick();
    no_plot(1'b0);
    tick();
`ifdef PIXEL_SINK_CLIP_EN
    check_val("clip_drop", 32'(drop_count), 2);
`else
    check_val("noclip_drop", 32'(drop_count), 0);
`endif
    drain("edge_drain");

    // 300 plots under pressure, then clear together with a plot
    rd_req  = 1'b1;
    rd_addr = 15'd22000;
    for (int i = 0; i < 300; i++) begin
      if (CLIP) drive_plot(8'd200, 7'd0, 3'd3, 1'b0);
      else drive_plot(8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 3'($urandom), 1'b0);
      tick();
      check_val("sat_drop", 32'(drop_count), 32'(exp_drop));
    end
    check_val("sat_ovf", 32'(overflow), 0);
    drive_plot(8'd0, 7'd120, 3'd2, 1'b1);
    tick();
    no_plot(1'b0);
    check_val("clr_drop", 32'(drop_count), 0);
    check_val("clr_ovf", 32'(overflow), 0);
    drain("sat_drain");

    // Randomized traffic
    rd_req = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      check_val("rand_drop", 32'(drop_count), 32'(exp_drop));
      if (!(rd_req && !ack_seen)) begin
        rd_req  = ($urandom_range(0, 2) == 0);
        rd_addr = 15'($urandom_range(20576, 32767));
      end
      if ($urandom_range(0, 1) == 1)
        drive_plot(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 3'($urandom),
                   ($urandom_range(0, 49) == 0));
      else no_plot($urandom_range(0, 49) == 0);
    end
    tick();
    check_val("rand_drop_end", 32'(drop_count), 32'(exp_drop));
    drain("rand_drain");
    check_val("rand_ovf", 32'(overflow), 0);

    // Reset mid-burst with 3 plots queued and reads in flight
    rd_req  = 1'b1;
    rd_addr = 15'd21000;
    drive_plot(8'd10, 7'd1, 3'd1, 1'b0);
    tick();
    drive_plot(8'd11, 7'd1, 3'd2, 1'b0);
    tick();
    drive_plot(8'd12, 7'd1, 3'd3, 1'b0);
    tick();
    no_plot(1'b0);
    #2;
    reset_n = 1'b0;
    rd_req  = 1'b0;
    wrq.delete();
    rdq.delete();
    exp_drop = 0;
    #1;
    check_val("mid_rst_we", 32'(mem_we), 0);
    check_val("mid_rst_full", 32'(full), 0);
    check_val("mid_rst_rd_valid", 32'(rd_valid), 0);
    check_val("mid_rst_rd_ack", 32'(rd_ack), 0);
    check_val("mid_rst_idle", 32'(idle), 1);
    check_val("mid_rst_addr", 32'(mem_addr), 0);
    check_val("mid_rst_wdata", 32'(mem_wdata), 0);
    check_val("mid_rst_rd_data", 32'(rd_data), 0);
    tick();
    tick();
    #2 reset_n = 1'b1;
    we_snap = n_we;
    repeat (8) tick();
    check_val("post_rst_no_we", 32'(n_we - we_snap), 0);
    drive_plot(8'd5, 7'd5, 3'd6, 1'b0);
    tick();
    no_plot(1'b0);
    tick();
    check_val("post_rst_we", 32'(mem_we), 1);
    check_val("post_rst_addr", 32'(mem_addr), 805);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_stream_sink.md
# pixel_stream_sink

Receiving end of the pixel-plot stream produced by the drawing blocks (x, y, colour, plot strobe). Buffers incoming plots in a small FIFO, range-checks them, converts coordinates to a linear frame address (y*160 + x) and drains them into an external single-port synchronous frame RAM. The same port is arbitrated with a scan-out read request, so one clock domain serves both the drawing path and the display path.

## Interface
- FIFO_DEPTH, 4, plot buffer entries; power of two, 2..16
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- x_in  in  8  plot x coordinate
- y_in  in  7  plot y coordinate
- colour_in  in  3  plot colour
- plot  in  1  plot strobe; one pixel per cycle high
- full  out  1  FIFO full; a plot sampled while full and not popping is dropped
- rd_req  in  1  scan-out read request; hold until rd_ack
- rd_addr  in  15  scan-out linear address
- rd_ack  out  1  read accepted at this edge
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  3  read colour
- mem_addr  out  15  RAM address, registered
- mem_wdata  out  3  RAM write data, registered
- mem_we  out  1  RAM write enable, registered
- mem_rdata  in  3  RAM read data, valid the cycle after the RAM samples the address
- clr_status  in  1  synchronous clear of drop_count and overflow
- drop_count  out  8  saturating count of dropped plots
- overflow  out  1  sticky: a plot was dropped because the FIFO was full
- idle  out  1  FIFO empty and no RAM access in flight

## Operation
- Push: at an edge with plot=1, {addr, colour} enters the FIFO, where addr = y_in*SCREEN_W + x_in (15 bits). A push into a full FIFO is accepted only if a pop occurs at the same edge; otherwise the plot is dropped, overflow is set and drop_count is incremented.
- Port arbiter FSM with states P_IDLE, P_RD and P_WR; a decision is made at every edge:
  - FIFO full and not empty: P_WR (pop). Writes win when the FIFO is full so the drawing path never stalls indefinitely.
  - else if rd_req: P_RD; rd_ack=1; mem_addr<=rd_addr, mem_we<=0.
  - else if FIFO not empty: P_WR; mem_addr/mem_wdata<=head entry, mem_we<=1.
  - else: P_IDLE, mem_we<=0.
- Read return: two edges after rd_ack, the block captures mem_rdata into rd_data and pulses rd_valid. Back-to-back reads are pipelined, one per cycle.
- drop_count saturates at 255. clr_status has priority over a same-edge drop, so that drop is not counted.
- Reset (asynchronous, any time): FIFO empties; full, mem_we, rd_ack, rd_valid, overflow and drop_count go to 0; mem_addr, mem_wdata and rd_data go to 0; idle goes to 1; FSM enters P_IDLE. An in-flight read is discarded, with no rd_valid.

## Timing
- Plot sampled at edge E0 -> mem_we=1 with that pixel after edge E1, provided no read wins at E1. Minimum write latency is 1 cycle.
- rd_req sampled and acked at E0 -> RAM samples the address at E1 -> rd_valid=1 after E2.
- full is combinational from the FIFO count: full=1 when count==FIFO_DEPTH.
- rd_ack is combinational from the arbiter decision at the coming edge.
- Sustained throughput is one RAM access per cycle. With continuous rd_req and a non-full FIFO, writes wait until the FIFO fills, then alternate with reads.
- FIFO pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.

## Configuration
- PIXEL_SINK_CLIP_EN defined: a plot with x_in>=SCREEN_W or y_in>=SCREEN_H is not pushed and increments drop_count; overflow is unaffected.
- PIXEL_SINK_CLIP_EN undefined: there is no range check. The address is computed unchecked (max 127*160+255=20575) and written to RAM as is.

## Test plan
- Single plot (x=3, y=2, colour=3'b010) into an idle block -> one cycle later mem_we=1, mem_addr=323, mem_wdata=2; then idle=1.
- Burst of 6 plots, one per cycle, with rd_req held high (FIFO_DEPTH=4) -> reads are acked until full=1, then writes interleave with reads. The 6 plots must land in RAM in order; drop_count=0 if pushes coincide with pops, otherwise overflow=1 with a matching count.
- rd_req with rd_addr=19199 where RAM holds 5 -> rd_ack at E0, rd_valid=1 and rd_data=5 after E2; two consecutive reads return in consecutive cycles.
- With PIXEL_SINK_CLIP_EN: plots at (160,0) and (0,120) -> no mem_we, drop_count=2. Without the macro: mem_addr=160 and 19200 are written.
- 300 drops -> drop_count=255; then clr_status together with a drop -> drop_count=0 and overflow=0.
- reset_n asserted low mid-burst, with 3 entries queued and a read in flight -> outputs are immediately at their reset values, no rd_valid, and no further mem_we after release until a new plot arrives.
